pga_alarm_annunciator: RTL and testbench

Operator-side responder for the PGA alarm line. It consumes the per-sample PGA threshold flag, confirms it over several consecutive cycles, and latches a confirmed event. While latched it drives the alarm LED and a beeping buzzer. A debounced operator acknowledge button clears the event and returns a one-cycle `o_accept` pulse to the detector path. It sits between the PGA threshold detector and the board I/O (LED, buzzer, push-button), and also keeps a saturating event count for status readout.

---
 rtl/eq_alarm_pkg.sv | 24 ++
 rtl/button_debounce.sv | 48 ++++
 rtl/pga_alarm_annunciator.sv | 120 ++++++++++++
 tb/tb_pga_alarm_annunciator.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/eq_alarm_pkg.sv
// Shared definitions for the PGA alarm path: annunciator state type,
// default tuning constants and the PGA sample width.
package eq_alarm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_ALARM   = 2'd2,
    ST_HOLDOFF = 2'd3
  } alarm_state_t;

  localparam int DEF_CONFIRM_CYCLES   = 4;
  localparam int DEF_DEBOUNCE_CYCLES  = 16;
  localparam int DEF_BEEP_HALF_PERIOD = 8;
  localparam int DEF_HOLDOFF_CYCLES   = 32;
  localparam int DEF_COUNT_WIDTH      = 8;
  localparam int SAMPLE_WIDTH         = 24;

  // Width of a counter that has to hold 0..n-1; never narrower than 1 bit.
  function automatic int cnt_w(input int n);
    return $clog2((n < 2) ? 2 : n);
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Operator push-button conditioner: 2-flop synchronizer, stable-time
// debouncer and a one-cycle pulse on the rising edge of the debounced level.
module button_debounce
  import eq_alarm_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_rise
);

  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic          sync_1;
  logic          sync_2;
  logic [DW-1:0] stable_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      stable_cnt <= '0;
      o_level    <= 1'b0;
      o_rise     <= 1'b0;
    end else begin
      sync_1 <= i_btn;
      sync_2 <= sync_1;
      o_rise <= 1'b0;
      // Any sample that agrees with the current level restarts the stable count.
      if (sync_2 != o_level) begin
        if (stable_cnt == DEB_LAST) begin
          o_level    <= sync_2;
          o_rise     <= sync_2;
          stable_cnt <= '0;
        end else begin
          stable_cnt <= stable_cnt + 1'b1;
        end
      end else begin
        stable_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/pga_alarm_annunciator.sv
// Operator-side alarm responder: confirms the PGA threshold flag, latches the
// event onto LED and buzzer, and clears it on a debounced acknowledge.
module pga_alarm_annunciator
  import eq_alarm_pkg::*;
#(
  parameter int CONFIRM_CYCLES   = DEF_CONFIRM_CYCLES,
  parameter int DEBOUNCE_CYCLES  = DEF_DEBOUNCE_CYCLES,
  parameter int BEEP_HALF_PERIOD = DEF_BEEP_HALF_PERIOD,
  parameter int HOLDOFF_CYCLES   = DEF_HOLDOFF_CYCLES,
  parameter int COUNT_WIDTH      = DEF_COUNT_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_pga_alarm,
  input  logic                   i_ack_btn,
  output logic                   o_accept,
  output logic                   o_alarm_active,
  output logic                   o_buzzer,
  output logic [COUNT_WIDTH-1:0] o_event_count,
  output alarm_state_t           o_state
);

  localparam int CW = cnt_w(CONFIRM_CYCLES);
  localparam int BW = cnt_w(BEEP_HALF_PERIOD);
  localparam int HW = cnt_w(HOLDOFF_CYCLES);
  localparam logic [CW-1:0] CONF_LAST = CW'(CONFIRM_CYCLES - 1);
  localparam logic [BW-1:0] BEEP_LAST = BW'(BEEP_HALF_PERIOD - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF_CYCLES - 1);

  alarm_state_t  state;
  logic [CW-1:0] conf_cnt;
  logic [BW-1:0] beep_cnt;
  logic [HW-1:0] hold_cnt;
  logic          ack_level;
  logic          ack_rise;
  logic          ack_pulse;
  logic          confirm_hit;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ack (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_btn  (i_ack_btn),
    .o_level(ack_level),
    .o_rise (ack_rise)
  );

  assign ack_pulse   = ack_rise & ack_level;
  assign confirm_hit = i_pga_alarm &&
                       (((state == ST_IDLE) && (CONFIRM_CYCLES == 1)) ||
                        ((state == ST_CONFIRM) && (conf_cnt == CONF_LAST)));
  assign o_state     = state;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= ST_IDLE;
      conf_cnt       <= '0;
      beep_cnt       <= '0;
      hold_cnt       <= '0;
      o_accept       <= 1'b0;
      o_alarm_active <= 1'b0;
      o_buzzer       <= 1'b0;
      o_event_count  <= '0;
    end else begin
      o_accept <= 1'b0;
      if (confirm_hit) begin
        // Entering ALARM: the buzzer starts high together with the LED.
        state          <= ST_ALARM;
        conf_cnt       <= '0;
        beep_cnt       <= '0;
        o_alarm_active <= 1'b1;
        o_buzzer       <= 1'b1;
        if (o_event_count != '1) o_event_count <= o_event_count + 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            if (i_pga_alarm) begin
              state    <= ST_CONFIRM;
              conf_cnt <= CW'(1);
            end
          end
          ST_CONFIRM: begin
            if (!i_pga_alarm) begin
              state    <= ST_IDLE;
              conf_cnt <= '0;
            end else begin
              conf_cnt <= conf_cnt + 1'b1;
            end
          end
          ST_ALARM: begin
            if (ack_pulse) begin
              state          <= ST_HOLDOFF;
              hold_cnt       <= '0;
              beep_cnt       <= '0;
              o_accept       <= 1'b1;
              o_alarm_active <= 1'b0;
              o_buzzer       <= 1'b0;
            end else if (beep_cnt == BEEP_LAST) begin
              beep_cnt <= '0;
              o_buzzer <= ~o_buzzer;
            end else begin
              beep_cnt <= beep_cnt + 1'b1;
            end
          end
          ST_HOLDOFF: begin
            if (hold_cnt == HOLD_LAST) begin
              state    <= ST_IDLE;
              hold_cnt <= '0;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pga_alarm_annunciator.sv
// Randomized scoreboard bench for pga_alarm_annunciator against a
// timestamp-style reference model of the annunciator rules.
module tb_pga_alarm_annunciator;
  import eq_alarm_pkg::*;

  localparam int CONF    = 4;
  localparam int DEB     = 16;
  localparam int BEEP    = 8;
  localparam int HOLD    = 32;
  localparam int COUNT_W = 2;
  localparam int CMAX    = (1 << COUNT_W) - 1;
  localparam int OW      = COUNT_W + 5;

  // clock / reset / DUT
  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_pga_alarm = 1'b0;
  logic               i_ack_btn = 1'b0;
  logic               o_accept;
  logic               o_alarm_active;
  logic               o_buzzer;
  logic [COUNT_W-1:0] o_event_count;
  alarm_state_t       o_state;

  always #5 i_clk = ~i_clk;

  pga_alarm_annunciator #(
    .CONFIRM_CYCLES  (CONF),
    .DEBOUNCE_CYCLES (DEB),
    .BEEP_HALF_PERIOD(BEEP),
    .HOLDOFF_CYCLES  (HOLD),
    .COUNT_WIDTH     (COUNT_W)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_pga_alarm   (i_pga_alarm),
    .i_ack_btn     (i_ack_btn),
    .o_accept      (o_accept),
    .o_alarm_active(o_alarm_active),
    .o_buzzer      (o_buzzer),
    .o_event_count (o_event_count),
    .o_state       (o_state)
  );

  // scoreboard
  logic [OW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int acc_exp = 0;
  int acc_seen = 0;
  int cyc = 0;

  // reference model: event latched flag, age since latch, holdoff time left,
  // consecutive-high run, raw button history and debounced-sample window
  bit m_latched, m_level, m_rise_prev, m_accept;
  int m_run, m_hold, m_age, m_count;
  bit raw_q[$];
  bit deb_q[$];

  task automatic model_step(input bit rst, input bit a, input bit b);
    bit seen, differ, rise;
    alarm_state_t st;
    if (rst) begin
      m_latched = 0; m_level = 0; m_rise_prev = 0; m_accept = 0;
      m_run = 0; m_hold = 0; m_age = 0; m_count = 0;
      raw_q.delete(); raw_q.push_back(1'b0); raw_q.push_back(1'b0);
      deb_q.delete();
    end else begin
      m_accept = 0;
      if (m_latched) begin
        if (m_rise_prev) begin
          m_latched = 0; m_accept = 1; m_hold = HOLD; acc_exp++;
        end else begin
          m_age++;
        end
      end else if (m_hold > 0) begin
        m_hold--;
      end else if (a) begin
        m_run++;
        if (m_run == CONF) begin
          m_latched = 1; m_age = 0; m_run = 0;
          if (m_count < CMAX) m_count++;
        end
      end else begin
        m_run = 0;
      end
      // button seen by the debouncer is the raw level from two edges back
      raw_q.push_back(b);
      seen = raw_q[0];
      void'(raw_q.pop_front());
      deb_q.push_back(seen);
      if (deb_q.size() > DEB) void'(deb_q.pop_front());
      differ = (deb_q.size() == DEB);
      foreach (deb_q[i]) if (deb_q[i] == m_level) differ = 0;
      rise = 0;
      if (differ) begin
        m_level = seen;
        rise = seen;
      end
      m_rise_prev = rise;
    end
    if (m_latched)       st = ST_ALARM;
    else if (m_hold > 0) st = ST_HOLDOFF;
    else if (m_run > 0)  st = ST_CONFIRM;
    else                 st = ST_IDLE;
    exp_q.push_back({st, m_accept, m_latched,
                     m_latched && (((m_age / BEEP) % 2) == 0),
                     COUNT_W'(m_count)});
  endtask

  // driver tasks
  task automatic drive(input bit rst, input bit a, input bit b);
    @(negedge i_clk);
    i_rst = rst;
    i_pga_alarm = a;
    i_ack_btn = b;
    model_step(rst, a, b);
  endtask

  task automatic run(input int n, input bit rst, input bit a, input bit b);
    for (int i = 0; i < n; i++) drive(rst, a, b);
  endtask

  task automatic press(input int len);
    run(len, 0, 0, 1);
    run(DEB + 8, 0, 0, 0);
  endtask

  // monitor: compare every cycle the DUT presents outputs
  initial begin
    logic [OW-1:0] got, want;
    forever begin
      @(posedge i_clk);
      #1;
      cyc++;
      if (o_accept) acc_seen++;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        got = {o_state, o_accept, o_alarm_active, o_buzzer, o_event_count};
        total++;
        if (got !== want) begin
          bad++;
          $display("FAIL outputs cyc=%0d got{st,acc,led,buz,cnt}=%b want=%b",
                   cyc, got, want);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  // stimulus
  initial begin
    run(3, 1, 0, 0);
    run(3, 0, 0, 0);
    // glitch rejection: 3 highs with a 4-cycle confirm
    run(3, 0, 1, 0);
    run(6, 0, 0, 0);
    // confirm, beep, latch survives the flag dropping
    run(4, 0, 1, 0);
    run(30, 0, 0, 0);
    // bouncy acknowledge then long hold: exactly one accept
    for (int i = 0; i < 5; i++) run(3, 0, 0, (i % 2) == 0);
    run(60, 0, 0, 1);
    run(DEB + 8, 0, 0, 0);
    // alarm held high through acknowledge and holdoff
    run(10, 0, 1, 0);
    run(DEB + 6, 0, 1, 1);
    run(HOLD + 20, 0, 1, 0);
    run(5, 0, 0, 0);
    press(DEB + 6);
    run(HOLD + 4, 0, 0, 0);
    // acknowledge while idle
    press(DEB + 10);
    // saturation from a clean reset
    run(2, 1, 0, 0);
    for (int e = 0; e < 5; e++) begin
      run(CONF + $urandom_range(0, 3), 0, 1, 0);
      run($urandom_range(2, 12), 0, 0, 0);
      press(DEB + $urandom_range(3, 10));
      run(HOLD + 2, 0, 0, 0);
    end
    // reset mid-ALARM while buzzer is high
    run(CONF, 0, 1, 0);
    run(2, 0, 0, 0);
    run(1, 1, 0, 0);
    run(6, 0, 0, 0);
    // random soak: alarm bursts, bounces and presses
    for (int s = 0; s < 120; s++) begin
      bit a, b;
      a = ($urandom_range(0, 2) != 0);
      b = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 40) == 0) run(1, 1, 0, 0);
      run($urandom_range(1, (b && $urandom_range(0, 1)) ? 30 : 8), 0, a, b);
    end
    run(DEB + HOLD, 0, 0, 0);
    repeat (2) @(posedge i_clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain queue_left=%0d want=0", exp_q.size());
    end
    total++;
    if (acc_seen != acc_exp) begin
      bad++;
      $display("FAIL accept_count got=%0d want=%0d", acc_seen, acc_exp);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
